// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues single-outstanding fetches, presents words to decode.
// Optional FETCH_CNT_EN adds a saturating accepted-instruction counter on o_instr_count.
module fetch_unit #(
    parameter int unsigned           PC_W     = 16,
    parameter int unsigned           INSTR_W  = 16,
    parameter logic [PC_W-1:0]       RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               o_imem_req,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_instr,
    output logic               o_instr_valid,
    output logic [PC_W-1:0]    o_pc_plus2,
    input  logic               i_dec_ready,
    input  logic               i_redirect,
    input  logic [PC_W-1:0]    i_redirect_pc,
    input  logic               i_halt,
    input  logic               i_err,
    output logic               o_halted,
`ifdef FETCH_CNT_EN
    output logic [15:0]        o_instr_count,
`endif
    output logic               o_err_halt
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StHalted} state_e;

    localparam logic [INSTR_W-1:0] NopInstr = INSTR_W'(16'h0800);

    state_e             r_state, w_state_d;
    logic [PC_W-1:0]    r_pc, w_pc_d;
    logic [INSTR_W-1:0] r_instr, w_instr_d;
    logic               r_valid, w_valid_d;
    logic               r_squash, w_squash_d;
    logic [PC_W-1:0]    r_target, w_target_d;
    logic               r_halted, w_halted_d;
    logic               r_err_halt, w_err_halt_d;
    logic               w_req;
    logic               w_accept;
    logic [PC_W-1:0]    w_pc_plus2;

    assign w_pc_plus2 = r_pc + PC_W'(2);

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_instr_d    = r_instr;
        w_valid_d    = r_valid;
        w_squash_d   = r_squash;
        w_target_d   = r_target;
        w_halted_d   = r_halted;
        w_err_halt_d = r_err_halt;
        w_req        = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            StIdle: w_state_d = StFetch;
            StFetch: begin
                w_req = 1'b1;
                if (i_imem_ack) begin
                    if (i_redirect) begin
                        w_pc_d     = i_redirect_pc;
                        w_squash_d = 1'b0;
                    end else if (r_squash) begin
                        w_pc_d     = r_target;
                        w_squash_d = 1'b0;
                    end else begin
                        w_instr_d = i_imem_rdata;
                        w_valid_d = 1'b1;
                        w_state_d = StHold;
                    end
                end else if (i_redirect) begin
                    // Request stays on the bus; its data is dropped when the ack arrives.
                    w_squash_d = 1'b1;
                    w_target_d = i_redirect_pc;
                end
            end
            StHold: begin
                if (i_halt || i_err) begin
                    w_valid_d    = 1'b0;
                    w_halted_d   = 1'b1;
                    w_err_halt_d = i_err;
                    w_state_d    = StHalted;
                end else if (i_redirect) begin
                    w_pc_d    = i_redirect_pc;
                    w_valid_d = 1'b0;
                    w_accept  = 1'b1;
                    w_state_d = StFetch;
                end else if (i_dec_ready) begin
                    w_pc_d    = w_pc_plus2;
                    w_valid_d = 1'b0;
                    w_accept  = 1'b1;
                    w_state_d = StFetch;
                end
            end
            StHalted: w_state_d = StHalted;
            default:  w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_instr    <= NopInstr;
            r_valid    <= 1'b0;
            r_squash   <= 1'b0;
            r_target   <= RESET_PC;
            r_halted   <= 1'b0;
            r_err_halt <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_instr    <= w_instr_d;
            r_valid    <= w_valid_d;
            r_squash   <= w_squash_d;
            r_target   <= w_target_d;
            r_halted   <= w_halted_d;
            r_err_halt <= w_err_halt_d;
        end
    end

`ifdef FETCH_CNT_EN
    logic [15:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 16'h0000;
        end else if (w_accept && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_instr_count = r_count;
`endif

    assign o_imem_req    = w_req;
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_pc_plus2    = w_pc_plus2;
    assign o_halted      = r_halted;
    assign o_err_halt    = r_err_halt;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table for fetch/accept/redirect, directed corner cases.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        dec_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        err = 1'b0;

    logic        imem_req, instr_valid, halted, err_halt;
    logic [15:0] imem_addr, instr, pc_plus2;
    logic        imem_req2, instr_valid2, halted2, err_halt2;
    logic [15:0] imem_addr2, instr2, pc_plus2_2;
`ifdef FETCH_CNT_EN
    logic [15:0] instr_count, instr_count2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instr(instr), .o_instr_valid(instr_valid), .o_pc_plus2(pc_plus2),
        .i_dec_ready(dec_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_halt(halt), .i_err(err), .o_halted(halted),
`ifdef FETCH_CNT_EN
        .o_instr_count(instr_count),
`endif
        .o_err_halt(err_halt)
    );

    fetch_unit #(.PC_W(16), .INSTR_W(16), .RESET_PC(16'hFFFE)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .o_imem_req(imem_req2), .o_imem_addr(imem_addr2),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .o_instr(instr2), .o_instr_valid(instr_valid2), .o_pc_plus2(pc_plus2_2),
        .i_dec_ready(dec_ready), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .i_halt(halt), .i_err(err), .o_halted(halted2),
`ifdef FETCH_CNT_EN
        .o_instr_count(instr_count2),
`endif
        .o_err_halt(err_halt2)
    );

    // act: 0 = dec_ready, 1 = redirect, 2 = redirect and dec_ready together
    typedef struct {
        int          lat;
        logic [15:0] rdata;
        int          act;
        logic [15:0] rpc;
        logic [15:0] exp_addr;
        logic [15:0] exp_pc2;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !imem_req; i++) tick();
        check("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic do_ack(input int lat, input logic [15:0] data);
        repeat (lat) tick();
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
    endtask

    task automatic check_count(input logic [15:0] exp);
`ifdef FETCH_CNT_EN
        check("instr_count", {16'd0, instr_count}, {16'd0, exp});
`else
        exp = exp;
`endif
    endtask

    initial begin
        vecs[0] = '{lat: 2, rdata: 16'h4105, act: 0, rpc: 16'h0000,
                    exp_addr: 16'h0000, exp_pc2: 16'h0002};
        vecs[1] = '{lat: 1, rdata: 16'h1111, act: 2, rpc: 16'h0040,
                    exp_addr: 16'h0002, exp_pc2: 16'h0004};
        vecs[2] = '{lat: 0, rdata: 16'h2222, act: 1, rpc: 16'h0101,
                    exp_addr: 16'h0040, exp_pc2: 16'h0042};
        vecs[3] = '{lat: 3, rdata: 16'h3333, act: 0, rpc: 16'h0000,
                    exp_addr: 16'h0101, exp_pc2: 16'h0103};

        repeat (3) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", {16'd0, imem_addr}, 32'h0000);
        check("rst_instr", {16'd0, instr}, 32'h0800);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc2", {16'd0, pc_plus2}, 32'h0002);
        check("rst_halted", {30'd0, halted, err_halt}, 32'd0);
        check_count(16'd0);
        rst_n = 1'b1;
        tick();
        check("idle_to_fetch", {31'd0, imem_req}, 32'd1);

        foreach (vecs[i]) begin
            wait_req();
            check($sformatf("v%0d_addr", i), {16'd0, imem_addr}, {16'd0, vecs[i].exp_addr});
            if (i == 0) check("wrap_addr", {16'd0, imem_addr2}, 32'hFFFE);
            do_ack(vecs[i].lat, vecs[i].rdata);
            check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, 32'd1);
            check($sformatf("v%0d_instr", i), {16'd0, instr}, {16'd0, vecs[i].rdata});
            check($sformatf("v%0d_pc2", i), {16'd0, pc_plus2}, {16'd0, vecs[i].exp_pc2});
            if (i == 0) check("wrap_pc2", {16'd0, pc_plus2_2}, 32'h0000);
            dec_ready   = (vecs[i].act != 1);
            redirect    = (vecs[i].act != 0);
            redirect_pc = vecs[i].rpc;
            tick();
            dec_ready = 1'b0;
            redirect  = 1'b0;
            check($sformatf("v%0d_drop", i), {31'd0, instr_valid}, 32'd0);
            if (i == 0) check("wrap_next", {16'd0, imem_addr2}, 32'h0000);
        end
        check_count(16'd4);

        // Redirect while the fetch at 0103 is outstanding: request held, data squashed.
        wait_req();
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        tick();
        redirect = 1'b0;
        check("sq_req_held", {31'd0, imem_req}, 32'd1);
        check("sq_addr_held", {16'd0, imem_addr}, 32'h0103);
        do_ack(1, 16'hBEEF);
        check("sq_valid", {31'd0, instr_valid}, 32'd0);
        check("sq_new_addr", {16'd0, imem_addr}, 32'h0100);

        // Redirect coincident with ack.
        redirect    = 1'b1;
        redirect_pc = 16'h0200;
        imem_ack    = 1'b1;
        imem_rdata  = 16'hCAFE;
        tick();
        redirect = 1'b0;
        imem_ack = 1'b0;
        check("rdack_valid", {31'd0, instr_valid}, 32'd0);
        check("rdack_addr", {16'd0, imem_addr}, 32'h0200);

        // Decoder inputs ignored while nothing is presented.
        halt      = 1'b1;
        err       = 1'b1;
        dec_ready = 1'b1;
        tick();
        halt      = 1'b0;
        err       = 1'b0;
        dec_ready = 1'b0;
        check("ign_halted", {31'd0, halted}, 32'd0);
        check("ign_addr", {16'd0, imem_addr}, 32'h0200);

        // HALT has priority over redirect/dec_ready and is terminal.
        do_ack(0, 16'h0000);
        check("h_instr", {16'd0, instr}, 32'h0000);
        halt        = 1'b1;
        dec_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        tick();
        halt = 1'b0;
        check("h_halted", {30'd0, halted, err_halt}, 32'b10);
        check("h_valid", {31'd0, instr_valid}, 32'd0);
        imem_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("h_no_req", {31'd0, imem_req}, 32'd0);
        end
        imem_ack  = 1'b0;
        dec_ready = 1'b0;
        redirect  = 1'b0;
        check_count(16'd4);

        rst_n = 1'b0;
        #1;
        check("rst2_req", {31'd0, imem_req}, 32'd0);
        check("rst2_addr", {16'd0, imem_addr}, 32'h0000);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check_count(16'd0);
        tick();
        rst_n = 1'b1;

        // Three sequential accepts, then err on the fourth word.
        for (int j = 0; j < 3; j++) begin
            wait_req();
            check($sformatf("seq%0d_addr", j), {16'd0, imem_addr}, 32'(2 * j));
            do_ack(1, 16'h1000 + 16'(j));
            dec_ready = 1'b1;
            tick();
            dec_ready = 1'b0;
        end
        check_count(16'd3);
        wait_req();
        check("e_addr", {16'd0, imem_addr}, 32'h0006);
        do_ack(1, 16'hF800);
        err = 1'b1;
        tick();
        err = 1'b0;
        check("e_halted", {30'd0, halted, err_halt}, 32'b11);
        repeat (3) tick();
        check_count(16'd3);

        // Asynchronous reset during an outstanding fetch drops the request at once.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wait_req();
        rst_n = 1'b0;
        #1;
        check("async_rst_req", {31'd0, imem_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
